// File: rtl/bo_mul_floatingpoint.sv
// ---------------------------------------------------------------------------
// bo_mul_floatingpoint
//   Multi-cycle IEEE-754 binary32 multiplier. A start pulse captures A/B,
//   then the FSM walks MUL -> NORM -> WRITE and the packed product appears
//   on the third rising edge after the start edge. Outputs hold until the
//   next WRITE or reset. Subnormal operands are flushed to zero. Rounding is
//   round-to-nearest, ties-to-even.
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   asynchronous, active-low reset
//   start         in   1   one-cycle request, A/B sampled on the same edge
//   A, B          in   32  binary32 operands
//   result        out  32  registered binary32 product
//   overflow_flag out  1   registered, high when the exponent overflowed
//   dbg_state     out  2   current FSM state (0 IDLE, 1 MUL, 2 NORM, 3 WRITE)
//
// Handshake: start is a single-cycle request accepted only in IDLE; there is
// no ready/valid pair. A request raised while busy is dropped, and the result
// is valid from the third edge after acceptance until the next WRITE.
// ---------------------------------------------------------------------------
module bo_mul_floatingpoint (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        overflow_flag,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_NORM  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t state, state_nx;

  // Captured operands and pipeline registers
  logic [31:0]       op_a, op_b;
  logic              prod_sign;
  logic signed [9:0] exp_sum;
  logic [47:0]       prod;
  logic signed [9:0] norm_exp;
  logic [22:0]       norm_frac;

  // Control strobes
  logic load_ops, do_mul, do_norm, do_write;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_MUL;
      S_MUL:   state_nx = S_NORM;
      S_NORM:  state_nx = S_WRITE;
      S_WRITE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    load_ops  = (state == S_IDLE) && start;
    do_mul    = (state == S_MUL);
    do_norm   = (state == S_NORM);
    do_write  = (state == S_WRITE);
    dbg_state = state;
  end

  // -------------------------------------------------------------------------
  // MUL stage: sign, biased exponent sum, full 24x24 significand product.
  // Subnormals still get the hidden 1 here; WRITE overrides them anyway.
  // -------------------------------------------------------------------------
  logic signed [9:0] exp_sum_nx;
  logic [47:0]       prod_nx;

  always_comb begin
    exp_sum_nx = $signed({2'b00, op_a[30:23]}) + $signed({2'b00, op_b[30:23]})
               - 10'sd127;
    prod_nx    = {24'd0, 1'b1, op_a[22:0]} * {24'd0, 1'b1, op_b[22:0]};
  end

  // -------------------------------------------------------------------------
  // NORM stage: the product of two [1,2) significands lies in [1,4), so at
  // most one right shift. Guard/round/sticky follow the kept 24 bits.
  // -------------------------------------------------------------------------
  logic [23:0]       mant_pre;
  logic              guard_b, round_b, sticky_b, round_up;
  logic [24:0]       mant_rnd;
  logic signed [9:0] exp_adj, exp_fin;
  logic [22:0]       frac_fin;

  always_comb begin
    if (prod[47]) begin
      mant_pre = prod[47:24];
      guard_b  = prod[23];
      round_b  = prod[22];
      sticky_b = |prod[21:0];
      exp_adj  = exp_sum + 10'sd1;
    end else begin
      mant_pre = prod[46:23];
      guard_b  = prod[22];
      round_b  = prod[21];
      sticky_b = |prod[20:0];
      exp_adj  = exp_sum;
    end
    // Ties go to the even significand: round up on an exact half only if LSB=1
    round_up = guard_b & (round_b | sticky_b | mant_pre[0]);
    mant_rnd = {1'b0, mant_pre} + {24'd0, round_up};
    if (mant_rnd[24]) begin
      // 1.111..1 rounded up to 10.000..0: fraction becomes zero, exponent +1
      frac_fin = 23'd0;
      exp_fin  = exp_adj + 10'sd1;
    end else begin
      frac_fin = mant_rnd[22:0];
      exp_fin  = exp_adj;
    end
  end

  // -------------------------------------------------------------------------
  // WRITE stage: special operands take priority over the computed value.
  // An exponent field of zero counts as zero (flush-to-zero).
  // -------------------------------------------------------------------------
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [31:0] pack_val;
  logic        pack_ovf;

  always_comb begin
    a_zero = (op_a[30:23] == 8'h00);
    b_zero = (op_b[30:23] == 8'h00);
    a_inf  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
    b_inf  = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
    a_nan  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
    b_nan  = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
    pack_ovf = 1'b0;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      pack_val = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      pack_val = {prod_sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      pack_val = {prod_sign, 31'd0};
    end else if (norm_exp >= 10'sd255) begin
      pack_val = {prod_sign, 8'hFF, 23'd0};
      pack_ovf = 1'b1;
    end else if (norm_exp <= 10'sd0) begin
      pack_val = {prod_sign, 31'd0};
    end else begin
      pack_val = {prod_sign, norm_exp[7:0], norm_frac};
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a          <= 32'd0;
      op_b          <= 32'd0;
      prod_sign     <= 1'b0;
      exp_sum       <= 10'sd0;
      prod          <= 48'd0;
      norm_exp      <= 10'sd0;
      norm_frac     <= 23'd0;
      result        <= 32'd0;
      overflow_flag <= 1'b0;
    end else begin
      if (load_ops) begin
        op_a <= A;
        op_b <= B;
      end
      if (do_mul) begin
        prod_sign <= op_a[31] ^ op_b[31];
        exp_sum   <= exp_sum_nx;
        prod      <= prod_nx;
      end
      if (do_norm) begin
        norm_exp  <= exp_fin;
        norm_frac <= frac_fin;
      end
      if (do_write) begin
        result        <= pack_val;
        overflow_flag <= pack_ovf;
      end
    end
  end

endmodule

// File: tb/tb_bo_mul_floatingpoint.sv
// ---------------------------------------------------------------------------
// tb_bo_mul_floatingpoint
//   Directed cases plus randomized operands checked against an arithmetic
//   reference model of binary32 multiplication (flush-to-zero, RNE).
// ---------------------------------------------------------------------------
module tb_bo_mul_floatingpoint;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        overflow_flag;
  logic [1:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bo_mul_floatingpoint dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .A             (A),
    .B             (B),
    .result        (result),
    .overflow_flag (overflow_flag),
    .dbg_state     (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  logic [32:0] exp_q[$];   // {overflow_flag, result}
  logic [32:0] last_out;   // what the outputs must hold between writes
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [32:0] got,
                          input logic [32:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got ovf=%0b res=%08h want ovf=%0b res=%08h",
               tag, got[32], got[31:0], want[32], want[31:0]);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: exact integer product, then round to 24 significant bits
  // -------------------------------------------------------------------------
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, sh, e;
    longint fa, fb, m, q, rem, half;
    logic   s;
    bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0] qv;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    a_nan  = (ea == 255) && (fa != 0);
    b_nan  = (eb == 255) && (fb != 0);
    a_inf  = (ea == 255) && (fa == 0);
    b_inf  = (eb == 255) && (fb == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero))
      return {1'b0, 32'h7FC0_0000};
    if (a_inf || b_inf)
      return {1'b0, s, 8'hFF, 23'd0};
    if (a_zero || b_zero)
      return {1'b0, s, 31'd0};
    m  = ((longint'(1) << 23) + fa) * ((longint'(1) << 23) + fb);
    sh = 0;
    while ((m >> sh) >= (longint'(1) << 24)) sh++;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    e = ea + eb - 127 - 23 + sh;
    if (q == (longint'(1) << 24)) begin
      q = q / 2;
      e++;
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, s, 31'd0};
    qv = 32'(q);
    return {1'b0, s, 8'(e), qv[22:0]};
  endfunction

  // Random operand biased toward special classes and exponent extremes
  function automatic logic [31:0] rand_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0:       begin e = 8'h00; if ($urandom_range(0, 1) == 0) f = 23'd0; end
      1:       begin e = 8'hFF; f = 23'd0; end
      2:       begin e = 8'hFF; f = f | 23'd1; end
      3:       e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 12))
                                                : 8'($urandom_range(243, 254));
      default: e = 8'($urandom_range(64, 190));
    endcase
    return {s, e, f};
  endfunction

  // -------------------------------------------------------------------------
  // Driver: issue one multiply, check hold before the write edge and the
  // result right after it. poke_busy raises start again during MUL with
  // different operands, which must be ignored.
  // -------------------------------------------------------------------------
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] want, input bit poke_busy,
                        input string tag);
    exp_q.push_back(want);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);                  // start edge has passed
    A = $urandom; B = $urandom;
    start = poke_busy;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;              // second edge after start
    check_eq({tag, "_hold"}, {overflow_flag, result}, last_out);
    @(posedge clk); #1;              // third edge: result written
    check_eq(tag, {overflow_flag, result}, exp_q.pop_front());
    last_out = want;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    last_out = 33'd0;
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;
    last_out = 33'd0;
    reset = 1'b0;
    start = 1'b0;
    A = 32'd0;
    B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", {overflow_flag, result}, 33'd0);
    @(negedge clk);
    reset = 1'b1;

    // No start: operands present but nothing must be written
    A = 32'h3FC0_0000; B = 32'h4000_0000;
    repeat (6) @(posedge clk);
    #1;
    check_eq("no_start", {overflow_flag, result}, 33'd0);

    // Directed cases
    do_reset();
    run_op(32'hF040_0000, 32'hF040_0000, {1'b1, 32'h7F80_0000}, 1'b0, "overflow");
    run_op(32'h3FC0_0000, 32'h4000_0000, {1'b0, 32'h4040_0000}, 1'b0, "mul_1p5x2");
    run_op(32'h0000_0000, 32'h7F80_0000, {1'b0, 32'h7FC0_0000}, 1'b0, "zero_x_inf");
    run_op(32'h7F80_0000, 32'h8000_0000, {1'b0, 32'h7FC0_0000}, 1'b0, "inf_x_nzero");
    run_op(32'hBF80_0000, 32'h7F80_0000, {1'b0, 32'hFF80_0000}, 1'b0, "neg_x_inf");
    run_op(32'h3F80_0001, 32'h3F80_0001, {1'b0, 32'h3F80_0002}, 1'b0, "round_small");
    run_op(32'h0080_0000, 32'h0080_0000, {1'b0, 32'h0000_0000}, 1'b0, "underflow");
    run_op(32'h3F80_0001, 32'h3FC0_0000, {1'b0, 32'h3FC0_0002}, 1'b0, "tie_odd_up");
    run_op(32'h3F80_0003, 32'h3FC0_0000, {1'b0, 32'h3FC0_0004}, 1'b0, "tie_even_keep");
    run_op(32'h7FC0_0000, 32'h3F80_0000, {1'b0, 32'h7FC0_0000}, 1'b0, "nan_in");
    run_op(32'h8000_0000, 32'h3F80_0000, {1'b0, 32'h8000_0000}, 1'b0, "neg_zero");
    run_op(32'h7F7F_FFFF, 32'h3F80_0001, {1'b1, 32'h7F80_0000}, 1'b0, "ovf_round");
    run_op(32'hC000_0000, 32'h4040_0000, {1'b0, 32'hC0C0_0000}, 1'b0, "neg_six");
    run_op(32'h3FC0_0000, 32'h4000_0000, {1'b0, 32'h4040_0000}, 1'b1, "busy_ignored");

    // Outputs must hold with no further starts
    repeat (5) @(posedge clk);
    #1;
    check_eq("hold_idle", {overflow_flag, result}, last_out);

    // Reset mid-operation: previous result is 3.0, then 3.0 x 3.0 is aborted
    @(negedge clk);
    A = 32'h4040_0000; B = 32'h4040_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("reset_mid_op", {overflow_flag, result}, 33'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("after_abort", {overflow_flag, result}, 33'd0);
    last_out = 33'd0;

    // Randomized operands against the model
    for (int i = 0; i < 300; i++) begin
      ra = rand_op();
      rb = rand_op();
      run_op(ra, rb, model(ra, rb), ($urandom_range(0, 7) == 0), "rand");
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end

    $display("final fsm state %0d", dbg_state);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bo_mul_floatingpoint.md
Name: bo_mul_floatingpoint

Overview:
- Multi-cycle IEEE-754 single-precision (binary32) multiplier with a start handshake.
- Captures operands on a start pulse and computes the product over a fixed 3-cycle FSM.
- Holds the product and an overflow flag until the next start or reset.
- Arithmetic leaf block used by datapath controllers that issue one multiply at a time.

Parameters:
- None. Format is fixed to binary32: 1 sign, 8 exponent (bias 127), 23 fraction bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; A/B sampled on the same edge
- A  input  32  operand A, binary32
- B  input  32  operand B, binary32
- result  output  32  product, binary32, registered
- overflow_flag  output  1  high when the product exponent overflowed; registered

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM forced to IDLE.
  - result=32'h00000000, overflow_flag=0, all internal registers cleared.
  - Reset mid-operation aborts the computation; no partial result is ever written.
- FSM states: IDLE -> MUL -> NORM -> WRITE -> IDLE.
  - IDLE: on a clock edge with start=1, latch A, B into operand registers and go to MUL. start=0 stays in IDLE; outputs unchanged.
  - MUL: sign = sA^sB; exp_sum = eA + eB - 127 (10-bit signed); 48-bit product of {1,fracA} x {1,fracB}.
  - NORM: if product bit47=1, shift right 1 and exp+1. Round to nearest, ties to even, using guard/round/sticky bits. Renormalize if rounding carries out.
  - WRITE: pack and update result/overflow_flag, return to IDLE.
- Latency: outputs update on the 3rd rising edge after the edge that sampled start, i.e. valid 3 cycles after start.
- A and B need be stable only on the start edge; later changes are ignored.
- start while busy (not IDLE) is ignored.
- Outputs hold their last value until the next WRITE or reset.
- Special operands, checked in WRITE with priority top to bottom:
  - Either operand NaN, or 0 x Inf: result=32'h7FC00000 (quiet NaN), overflow_flag=0.
  - Either operand Inf: result={sign,8'hFF,23'h0}, overflow_flag=0.
  - Either operand zero or subnormal (exponent field 0): subnormals are flushed to zero; result={sign,31'h0}, overflow_flag=0.
- Normal operands:
  - Final exponent >= 255: overflow. result={sign,8'hFF,23'h0} (±Inf), overflow_flag=1.
  - Final exponent <= 0: underflow, flushed to {sign,31'h0}, overflow_flag=0.
  - Otherwise: result={sign,exp[7:0],frac[22:0]}, overflow_flag=0.
- overflow_flag is recomputed on every WRITE; it is not sticky across operations.

Test Plan:
- Overflow: reset low 2 cycles, release; A=B=32'hF0400000 (-1.5*2^97) with start=1 for one cycle. After 3 cycles: result=32'h7F800000, overflow_flag=1.
- Normal multiply: reset, then A=32'h3FC00000 (1.5), B=32'h40000000 (2.0), start pulse. After 3 cycles: result=32'h40400000 (3.0), overflow_flag=0. Zeroing A/B one cycle after start does not change the result.
- No start: reset, apply A=32'h3FC00000, B=32'h40000000 with start=0 for 6 cycles. Result stays 32'h00000000, overflow_flag stays 0.
- Specials:
  - A=32'h00000000, B=32'h7F800000 -> 32'h7FC00000.
  - A=32'hBF800000 (-1.0), B=32'h7F800000 -> 32'hFF800000, overflow_flag=0.
- Rounding and underflow:
  - A=32'h3F800001, B=32'h3F800001 -> 32'h3F800002.
  - A=32'h00800000, B=32'h00800000 -> 32'h00000000.
- Reset mid-operation: assert reset one cycle after start for A=3.0, B=3.0. Result=0 and overflow_flag=0 immediately. No update occurs after reset is released.
